// File: rtl/hkspi_slave_if.sv
// rtl/hkspi_slave_if.sv - housekeeping SPI pad and register-bus signal bundle
interface hkspi_slave_if;
    logic       spi_sck;
    logic       spi_csb;
    logic       spi_sdi;
    logic       spi_sdo;
    logic       spi_sdo_oe;
    logic [7:0] reg_addr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       busy;

    // Protocol engine side
    modport slave (
        input  spi_sck, spi_csb, spi_sdi, reg_rdata,
        output spi_sdo, spi_sdo_oe, reg_addr, reg_rd, reg_wr, reg_wdata, busy
    );

    // Pad driver / register file side
    modport master (
        output spi_sck, spi_csb, spi_sdi, reg_rdata,
        input  spi_sdo, spi_sdo_oe, reg_addr, reg_rd, reg_wr, reg_wdata, busy
    );
endinterface

// File: rtl/hkspi_slave.sv
// rtl/hkspi_slave.sv - housekeeping SPI slave: oversampled command/address/data engine
module hkspi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          resetb,
    hkspi_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_d;
    logic                   sck_s;
    logic                   csb_s;
    logic                   sdi_s;
    logic                   rise;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [2:0] count;
    logic       rd_mode;
    logic       wr_mode;
    logic [6:0] rx_sr;
    logic [7:0] rx_next;
    logic [6:0] tx_sr;
    logic [1:0] step;
    logic       load_pend;

    logic       sdo_q;
    logic       sdo_oe_q;
    logic [7:0] addr_q;
    logic       rd_q;
    logic       wr_q;
    logic [7:0] wdata_q;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign csb_s   = csb_sync[SYNC_STAGES-1];
    assign sdi_s   = sdi_sync[SYNC_STAGES-1];
    assign rise    = sck_s & ~sck_d;
    assign rx_next = {rx_sr, sdi_s};

    assign bus.spi_sdo    = sdo_q;
    assign bus.spi_sdo_oe = sdo_oe_q;
    assign bus.reg_addr   = addr_q;
    assign bus.reg_rd     = rd_q;
    assign bus.reg_wr     = wr_q;
    assign bus.reg_wdata  = wdata_q;
    assign bus.busy       = ~csb_s;

    // Pad synchronisers; CSB resets high so the engine starts deselected
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], bus.spi_csb};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.spi_sdi};
            sck_d    <= sck_s;
        end
    end

    // Protocol FSM with byte-boundary sequencing and registered bus outputs
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 3'd0;
            count     <= 3'd0;
            rd_mode   <= 1'b0;
            wr_mode   <= 1'b0;
            rx_sr     <= 7'd0;
            tx_sr     <= 7'd0;
            step      <= 2'd0;
            load_pend <= 1'b0;
            sdo_q     <= 1'b0;
            sdo_oe_q  <= 1'b0;
            addr_q    <= 8'h00;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 8'h00;
        end else begin
            // Strobes are single-cycle; read data is captured the cycle after the strobe
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            load_pend <= rd_q;

            if (load_pend) begin
                tx_sr    <= bus.reg_rdata[6:0];
                sdo_q    <= bus.reg_rdata[7];
                sdo_oe_q <= 1'b1;
            end

            // After a data byte: bump the address, then prefetch the next read byte
            case (step)
                2'd1: begin
                    addr_q <= addr_q + 8'd1;
                    step   <= 2'd2;
                end
                2'd2: begin
                    step <= 2'd0;
                    if (rd_mode && state == ST_DATA) begin
                        rd_q <= 1'b1;
                    end
                end
                default: step <= 2'd0;
            endcase

            case (state)
                ST_IDLE: begin
                    if (!csb_s) begin
                        state   <= ST_CMD;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        rx_sr   <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr_mode <= rx_next[7];
                            rd_mode <= rx_next[6];
                            count   <= rx_next[5:3];
                            state   <= (rx_next[7:6] == 2'b00) ? ST_DONE : ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        rx_sr   <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr_q   <= rx_next;
                            byte_cnt <= 3'd0;
                            state    <= ST_DATA;
                            if (rd_mode) begin
                                rd_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rise) begin
                        rx_sr   <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (rd_mode) begin
                            sdo_q <= tx_sr[6];
                            tx_sr <= {tx_sr[5:0], 1'b0};
                        end
                        if (bit_cnt == 3'd7) begin
                            if (wr_mode) begin
                                wr_q    <= 1'b1;
                                wdata_q <= rx_next;
                            end
                            step     <= 2'd1;
                            byte_cnt <= byte_cnt + 3'd1;
                            if (count != 3'd0 && (byte_cnt + 3'd1) == count) begin
                                state    <= ST_DONE;
                                sdo_oe_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    sdo_oe_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            // Deselect wins over everything: drop the partial byte and any pending work
            if (csb_s) begin
                state     <= ST_IDLE;
                bit_cnt   <= 3'd0;
                step      <= 2'd0;
                load_pend <= 1'b0;
                rd_q      <= 1'b0;
                sdo_q     <= 1'b0;
                sdo_oe_q  <= 1'b0;
            end
        end
    end

endmodule
